// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch-stage bus: decode-side controls, imem port and IF/ID outputs
interface if_stage_if;
    logic        stall;
    logic        flush;
    logic        br_taken;
    logic [31:0] br_target;
    logic        j_en;
    logic [31:0] j_target;
    logic        jr_en;
    logic [31:0] jr_target;
    logic [31:0] im_addr;
    logic [31:0] im_data;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc8;
    logic        id_valid;
    logic        id_exc;

    modport master (
        output stall, flush, br_taken, br_target, j_en, j_target, jr_en, jr_target, im_data,
        input  im_addr, id_instr, id_pc, id_pc8, id_valid, id_exc
    );

    modport slave (
        input  stall, flush, br_taken, br_target, j_en, j_target, jr_en, jr_target, im_data,
        output im_addr, id_instr, id_pc, id_pc8, id_valid, id_exc
    );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction fetch: PC, next-PC select, fetch fault check, IF/ID register
module if_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 4096
) (
    input  logic       clk,
    input  logic       reset,
    if_stage_if.slave  bus
);
    // 33-bit bounds so a window ending at 2^32 never wraps to zero
    localparam logic [32:0] IM_LO = {1'b0, IM_BASE};
    localparam logic [32:0] IM_HI = IM_LO + (33'(IM_WORDS) << 2);

    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [32:0] pc_ext;
    logic        fault;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc8;
    logic        id_valid;
    logic        id_exc;

    assign bus.im_addr  = pc;
    assign bus.id_instr = id_instr;
    assign bus.id_pc    = id_pc;
    assign bus.id_pc8   = id_pc8;
    assign bus.id_valid = id_valid;
    assign bus.id_exc   = id_exc;

    assign pc_ext = {1'b0, pc};

    always_comb begin
        fault = (pc[1:0] != 2'b00) || (pc_ext < IM_LO) || (pc_ext >= IM_HI);
    end

    always_comb begin
        next_pc = pc + 32'd4;
        if (bus.jr_en) begin
            next_pc = bus.jr_target;
        end else if (bus.j_en) begin
            next_pc = bus.j_target;
        end else if (bus.br_taken) begin
            next_pc = bus.br_target;
        end
    end

    // The instruction in IF when a redirect arrives is the delay slot and is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= PC_RESET;
            id_instr <= 32'd0;
            id_pc    <= 32'd0;
            id_pc8   <= 32'd0;
            id_valid <= 1'b0;
            id_exc   <= 1'b0;
        end else begin
            if (!bus.stall) begin
                pc <= next_pc;
            end
            if (bus.flush) begin
                id_instr <= 32'd0;
                id_valid <= 1'b0;
                id_exc   <= 1'b0;
            end else if (!bus.stall) begin
                id_pc    <= pc;
                id_pc8   <= pc + 32'd8;
                id_valid <= 1'b1;
                id_exc   <= fault;
                id_instr <= fault ? 32'd0 : bus.im_data;
            end
        end
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the program counter and drives the instruction-memory word address.
- Selects the next PC from sequential, branch, jump and register-jump sources, and latches the returned instruction into the IF/ID pipeline register.
- Handles stall, flush and fetch-address faults; its outputs feed the decode stage.

Parameters:
PC_RESET, 32'h00003000, PC value loaded on reset
IM_BASE, 32'h00003000, byte address of instruction-memory word 0
IM_WORDS, 4096, instruction-memory depth in 32-bit words

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hazard stall from decode; freezes PC and IF/ID
flush  in  1  squash the instruction entering IF/ID
br_taken  in  1  decode-stage branch resolved taken
br_target  in  32  branch target byte address
j_en  in  1  j/jal in decode
j_target  in  32  jump target byte address
jr_en  in  1  jr/jalr in decode
jr_target  in  32  register jump target
im_addr  out  32  current PC, to instruction memory
im_data  in  32  instruction word returned combinationally for im_addr
id_instr  out  32  IF/ID instruction
id_pc  out  32  IF/ID PC
id_pc8  out  32  IF/ID PC+8 (link value)
id_valid  out  1  IF/ID holds a real instruction
id_exc  out  1  IF/ID instruction carries a fetch-address fault

Behaviour:
- All state updates on rising clk only. reset has priority over every other input.
- Reset values:
  - pc = PC_RESET.
  - id_instr = 0 (nop), id_pc = 0, id_pc8 = 0, id_valid = 0, id_exc = 0.
- Address output: im_addr = pc, purely combinational from the PC register, zero added latency. im_data is valid in the same cycle.
- Fetch fault: fault = (pc[1:0] != 0) OR (pc < IM_BASE) OR (pc >= IM_BASE + 4*IM_WORDS). The range comparison uses a 33-bit unsigned compare, so there is no wrap at 2^32.
- Next-PC priority, highest first:
  - jr_en -> jr_target
  - j_en -> j_target
  - br_taken -> br_target
  - otherwise pc+4, modulo 2^32
- Targets are loaded unmodified. A misaligned target is caught by the fault check on the next cycle, not masked.
- Delay slot: a redirect does not squash the instruction currently in IF. That instruction is the architectural delay slot and enters IF/ID normally.
- Per-cycle update, with reset low:
  - stall=1, flush=0: pc and all IF/ID outputs hold. Redirect inputs are ignored, because decode re-presents them while stalled.
  - stall=1, flush=1: pc holds. IF/ID is cleared: id_instr=0, id_valid=0, id_exc=0; id_pc and id_pc8 hold.
  - stall=0, flush=1: pc takes next-PC. IF/ID is cleared as above.
  - stall=0, flush=0: pc takes next-PC, id_pc = pc, id_pc8 = pc+8, id_valid = 1.
    - No fault: id_instr = im_data, id_exc = 0.
    - Fault: id_instr = 0, id_exc = 1. im_data is ignored on a fault.
- PC keeps advancing after a fault. Decode/exception logic is responsible for redirecting it.
- A reset asserted mid-stall or mid-redirect fully reinitialises pc and IF/ID on that edge. The first fetch after reset is PC_RESET, with id_valid rising one cycle after reset deasserts.
- No other internal state. All outputs are registers, except im_addr, which is a direct register output.

Test Plan:
1. Reset then 4 free-running cycles with im_data = 0x20080001 -> im_addr steps 0x3000, 0x3004, 0x3008, 0x300C. IF/ID shows id_pc = 0x3000, then 0x3004; id_pc8 = 0x3008; id_valid = 1.
2. At pc = 0x3010, assert br_taken with br_target = 0x3040 for 1 cycle -> next im_addr = 0x3040. The instruction at 0x3010 (delay slot) reaches IF/ID with id_valid = 1.
3. Assert jr_en (0x3100), j_en (0x3200) and br_taken (0x3300) together -> im_addr = 0x3100.
4. Hold stall for 3 cycles at pc = 0x3020 while toggling br_taken -> im_addr stays 0x3020 and IF/ID is unchanged. On release, fetch resumes at 0x3024 and br_taken is honoured only if still asserted.
5. Redirect to jr_target = 0x3002, then to 0x00002FFC, then to 0x00007000 -> id_exc = 1 and id_instr = 0 for each of the three. The following sequential fetches also fault until redirected in range.
6. Assert flush with stall = 0, then flush with stall = 1; then assert reset during stall at pc = 0x3050 -> IF/ID is cleared (id_valid = 0) in both flush cases, and pc holds in the stall case. The reset edge gives pc = 0x3000 and all IF/ID outputs = 0.
